mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus write-back logic of the five-stage MIPS core.
//  Captures memory-stage results, extracts/extends load data, selects the result and
//  drives the register file write port (we3/wa3/wd3) and the debug write-back trace.
//  Sits directly upstream of the register file; the write port is decoded in this block.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000  value of debug_wb_pc after reset
// PORTS
//  clk              in   1   core clock; all state updates on rising edge
//  rst              in   1   synchronous reset, active-high
//  stallW           in   1   hold WB register contents
//  flushW           in   1   squash WB register to a bubble
//  validM           in   1   MEM-stage instruction is valid
//  pcM              in   32  MEM-stage PC
//  regwriteM        in   1   instruction writes a GPR
//  memtoregM        in   1   result comes from load data
//  loadtypeM        in   3   LW/LB/LBU/LH/LHU code (shared package)
//  writeregM        in   5   destination GPR number
//  aluoutM          in   32  ALU result / effective address
//  readdataM        in   32  raw data-memory word
//  regwriteW        out  1   to regfile we3
//  writeregW        out  5   to regfile wa3
//  resultW          out  32  to regfile wd3 and forwarding network
//  debug_wb_pc      out  32  trace PC of retiring instruction
//  debug_wb_rf_wen  out  4   trace byte write enables (4'hF or 4'h0)
//  debug_wb_rf_wnum out  5   trace GPR number
//  debug_wb_rf_wdata out 32  trace write data
// BEHAVIOUR
//  - Latency 1: MEM inputs sampled on a rising edge appear at WB outputs after that edge.
//  - Edge priority: rst > flushW > stallW > capture.
//  - rst: valid=0, regwrite=0, writereg=0, aluout/readdata=0, loadtype=LW, pc=RESET_PC,
//    reported=0. So after reset: regwriteW=0, writeregW=0, resultW=0, debug_wb_rf_wen=0,
//    debug_wb_rf_wnum=0, debug_wb_rf_wdata=0, debug_wb_pc=RESET_PC.
//  - flushW: same as rst except pc holds its value; the squashed slot writes nothing.
//  - stallW: every field held; regwriteW stays asserted (rewrite of same value harmless).
//  - Capture: all fields loaded from MEM; reported cleared to 0.
//  - regwriteW = valid & regwrite & (writereg != 0); writes to $0 are never issued.
//  - Load extraction on registered aluout[1:0] and readdata (little-endian):
//    LW: word; LB/LBU: byte aluout[1:0], sign/zero-extended;
//    LH/LHU: halfword aluout[1]=0 -> [15:0], 1 -> [31:16]; aluout[0] ignored
//    (misalignment is trapped upstream).
//  - resultW = memtoreg ? extracted : aluout; combinational from WB registers.
//  - Trace: debug_wb_rf_wen = {4{regwriteW & ~reported}}; wnum/wdata = writeregW/resultW
//    when wen!=0, else 0. reported sets to 1 on any edge where stallW=1 and the slot is
//    valid, so a stalled instruction is reported exactly once (its first WB cycle).
//  - flushW and stallW together: flush wins; slot becomes a bubble.
//  - Reset asserted mid-stall: reset wins; no trace entry for the discarded instruction.
// STRUCTURE
//  - Shared package mips_defines: LOADTYPE_LW/LB/LBU/LH/LHU codes (3-bit), RESET_PC value.
//  - One combinational sub-module load_align (loadtype, addr[1:0], word -> data32);
//    pipeline register, reported flag and trace logic in this module.
// TESTING
//  - rst=1 two cycles -> all outputs at reset values above, debug_wb_pc=32'hBFC0_0000.
//  - ALU op: regwriteM=1, writeregM=5'd8, aluoutM=32'h1234_5678, memtoregM=0 -> next cycle
//    regwriteW=1, writeregW=8, resultW=32'h1234_5678, debug_wb_rf_wen=4'hF.
//  - Loads, readdataM=32'h8081_F27F: LB addr[1:0]=2 -> FFFF_FF81; LBU addr 3 -> 0000_0080;
//    LH addr 0 -> FFFF_F27F; LHU addr 2 -> 0000_8081; LW -> 8081_F27F.
//  - writeregM=0 with regwriteM=1 -> regwriteW=0, debug_wb_rf_wen=0.
//  - Valid write then stallW=1 for 3 cycles -> regwriteW=1 all 4 cycles, debug_wb_rf_wen=4'hF
//    first cycle only, outputs unchanged while stalled.
//  - flushW=1 with stallW=1 on valid write -> next cycle regwriteW=0, wen=0, pc held.

Source files
------------

// File: rtl/mips_defines.sv
// mips_defines: shared load-type codes and reset PC for the MIPS core
package mips_defines;
    localparam logic [2:0] LOADTYPE_LW  = 3'd0;
    localparam logic [2:0] LOADTYPE_LB  = 3'd1;
    localparam logic [2:0] LOADTYPE_LBU = 3'd2;
    localparam logic [2:0] LOADTYPE_LH  = 3'd3;
    localparam logic [2:0] LOADTYPE_LHU = 3'd4;
    localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
endpackage

// File: rtl/load_align.sv
// load_align: little-endian byte/halfword extraction with sign/zero extension
module load_align
    import mips_defines::*;
(
    input  logic [2:0]  loadtype,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{addr, 3'b000} +: 8];
        // addr[0] is ignored for halfwords; misalignment traps before this stage
        h = addr[1] ? word[31:16] : word[15:0];
        data = loadtype == LOADTYPE_LB  ? {{24{b[7]}}, b} :
               loadtype == LOADTYPE_LBU ? {24'b0, b} :
               loadtype == LOADTYPE_LH  ? {{16{h[15]}}, h} :
               loadtype == LOADTYPE_LHU ? {16'b0, h} : word;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, load extraction, result select and
// register-file write port with debug write-back trace
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = mips_defines::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallW,
    input  logic        flushW,
    input  logic        validM,
    input  logic [31:0] pcM,
    input  logic        regwriteM,
    input  logic        memtoregM,
    input  logic [2:0]  loadtypeM,
    input  logic [4:0]  writeregM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] readdataM,
    output logic        regwriteW,
    output logic [4:0]  writeregW,
    output logic [31:0] resultW,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);
    import mips_defines::*;
    logic        valid_r, regwrite_r, memtoreg_r, reported_r;
    logic [2:0]  loadtype_r;
    logic [4:0]  writereg_r;
    logic [31:0] aluout_r, readdata_r, pc_r, load_data;
    always_ff @(posedge clk) begin
        if (rst || flushW) begin
            valid_r    <= 1'b0;
            regwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
            loadtype_r <= LOADTYPE_LW;
            writereg_r <= 5'd0;
            aluout_r   <= 32'd0;
            readdata_r <= 32'd0;
            reported_r <= 1'b0;
            pc_r       <= rst ? RESET_PC : pc_r;
        end else if (stallW) begin
            // a stalled slot keeps writing but is traced only in its first cycle
            reported_r <= reported_r | valid_r;
        end else begin
            valid_r    <= validM;
            regwrite_r <= regwriteM;
            memtoreg_r <= memtoregM;
            loadtype_r <= loadtypeM;
            writereg_r <= writeregM;
            aluout_r   <= aluoutM;
            readdata_r <= readdataM;
            pc_r       <= pcM;
            reported_r <= 1'b0;
        end
    end
    load_align u_load_align (
        .loadtype(loadtype_r),
        .addr    (aluout_r[1:0]),
        .word    (readdata_r),
        .data    (load_data)
    );
    always_comb begin
        regwriteW         = valid_r & regwrite_r & (writereg_r != 5'd0);
        writeregW         = writereg_r;
        resultW           = memtoreg_r ? load_data : aluout_r;
        debug_wb_pc       = pc_r;
        debug_wb_rf_wen   = {4{regwriteW & ~reported_r}};
        debug_wb_rf_wnum  = |debug_wb_rf_wen ? writeregW : 5'd0;
        debug_wb_rf_wdata = |debug_wb_rf_wen ? resultW : 32'd0;
    end
endmodule
